// File: rtl/kronos_x_heep_pkg.sv
// Kronos/X-HEEP integration constants: data-port arbiter sizing and bus slave index.
package kronos_x_heep_pkg;

  localparam int unsigned KRONOS_ARB_NMASTER         = 2;
  localparam int unsigned KRONOS_ARB_MAX_OUTSTANDING = 2;
  localparam int unsigned KRONOS_SLAVE_IDX           = 4;

endpackage

// File: rtl/obi_pkg.sv
// OBI request/response bundles shared by the Kronos subsystem bus fabric.
package obi_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/kronos_obi_arb_idfifo.sv
// In-order FIFO of master indices for granted-but-unanswered OBI transactions.
module kronos_obi_arb_idfifo #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned DATA_W = 1,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] head,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic              push_ok;
  logic              pop_ok;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr] <= data_in;
  end

endmodule

// File: rtl/kronos_obi_arbiter.sv
// Round-robin OBI arbiter sharing the Kronos data slave port among several masters,
// with address-phase locking and in-order response routing.
module kronos_obi_arbiter
  import obi_pkg::*;
  import kronos_x_heep_pkg::*;
#(
  parameter int unsigned NUM_MASTERS     = KRONOS_ARB_NMASTER,
  parameter int unsigned MAX_OUTSTANDING = KRONOS_ARB_MAX_OUTSTANDING,
  localparam int unsigned IDX_W          = $clog2(NUM_MASTERS),
  localparam int unsigned CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  obi_req_t         master_req_i  [NUM_MASTERS],
  output obi_resp_t        master_resp_o [NUM_MASTERS],
  output obi_req_t         slave_req_o,
  input  obi_resp_t        slave_resp_i,
  output logic [CNT_W-1:0] outstanding_o,
  output logic             err_o
);

  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] locked_idx;
  logic [IDX_W-1:0] rr_sel;
  logic [IDX_W-1:0] cand;
  logic [IDX_W-1:0] sel;
  logic [IDX_W-1:0] head;
  logic             lock;
  logic             full;
  logic             empty;
  logic             handshake;
  logic             pop;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(NUM_MASTERS - 1)) ? '0 : i + IDX_W'(1);
  endfunction

  // Scan from the farthest candidate down so the requester nearest rr_ptr wins.
  always_comb begin
    rr_sel = rr_ptr;
    cand   = rr_ptr;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      cand = IDX_W'((int'(rr_ptr) + i) % NUM_MASTERS);
      if (master_req_i[cand].req) rr_sel = cand;
    end
  end

  assign sel = lock ? locked_idx : rr_sel;

  always_comb begin
    slave_req_o     = master_req_i[sel];
    slave_req_o.req = master_req_i[sel].req & ~full;
  end

  assign handshake = slave_req_o.req & slave_resp_i.gnt;
  assign pop       = slave_resp_i.rvalid & ~empty;

  always_comb begin
    for (int i = 0; i < NUM_MASTERS; i++) begin
      master_resp_o[i].gnt    = handshake && (sel == IDX_W'(i));
      master_resp_o[i].rvalid = pop && (head == IDX_W'(i));
      master_resp_o[i].rdata  = slave_resp_i.rdata;
    end
  end

  // A pending ungranted request pins the selection so the address phase stays stable.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr     <= '0;
      lock       <= 1'b0;
      locked_idx <= '0;
      err_o      <= 1'b0;
    end else begin
      if (handshake) begin
        rr_ptr <= next_idx(sel);
        lock   <= 1'b0;
      end else if (slave_req_o.req) begin
        lock       <= 1'b1;
        locked_idx <= sel;
      end
      if (slave_resp_i.rvalid && empty) err_o <= 1'b1;
    end
  end

  kronos_obi_arb_idfifo #(
    .DEPTH  (MAX_OUTSTANDING),
    .DATA_W (IDX_W)
  ) u_idfifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push    (handshake),
    .pop     (pop),
    .data_in (sel),
    .head    (head),
    .count   (outstanding_o),
    .full    (full),
    .empty   (empty)
  );

endmodule

// File: tb/tb_kronos_obi_arbiter.sv
// Directed bench for kronos_obi_arbiter with a per-cycle queue-based reference model.
module tb_kronos_obi_arbiter;
  import obi_pkg::*;

  localparam int NM = 2;
  localparam int MO = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  obi_req_t   mreq  [NM];
  obi_resp_t  mresp [NM];
  obi_req_t   sreq;
  obi_resp_t  sresp;
  logic [1:0] outstanding;
  logic       err;

  int checks = 0;
  int errors = 0;

  kronos_obi_arbiter #(
    .NUM_MASTERS     (NM),
    .MAX_OUTSTANDING (MO)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .master_req_i  (mreq),
    .master_resp_o (mresp),
    .slave_req_o   (sreq),
    .slave_resp_i  (sresp),
    .outstanding_o (outstanding),
    .err_o         (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: state reflects what the arbiter should hold during the current cycle.
  int  m_q[$];
  int  m_rr    = 0;
  int  m_lidx  = 0;
  bit  m_lock  = 0;
  bit  m_err   = 0;
  bit  m_valid = 0;

  always @(negedge clk) begin
    int  sel;
    int  head;
    bit  found;
    bit  full;
    bit  exp_req;
    bit  hs;
    bit  pop;
    sel   = m_rr;
    found = 0;
    if (m_lock) sel = m_lidx;
    else begin
      for (int k = 0; k < NM; k++) begin
        if (!found && mreq[(m_rr + k) % NM].req) begin
          sel   = (m_rr + k) % NM;
          found = 1;
        end
      end
    end
    full    = (m_q.size() == MO);
    exp_req = mreq[sel].req && !full;
    hs      = exp_req && sresp.gnt;
    pop     = sresp.rvalid && (m_q.size() != 0);
    head    = pop ? m_q[0] : -1;

    if (m_valid) begin
      chk("model_slave_req", 32'(sreq.req), 32'(exp_req));
      if (exp_req) begin
        chk("model_slave_addr", sreq.addr, mreq[sel].addr);
        chk("model_slave_wdata", sreq.wdata, mreq[sel].wdata);
        chk("model_slave_we_be", {27'd0, sreq.we, sreq.be}, {27'd0, mreq[sel].we, mreq[sel].be});
      end
      for (int i = 0; i < NM; i++) begin
        chk($sformatf("model_gnt_m%0d", i), 32'(mresp[i].gnt), 32'(hs && (i == sel)));
        chk($sformatf("model_rvalid_m%0d", i), 32'(mresp[i].rvalid), 32'(pop && (i == head)));
        chk($sformatf("model_rdata_m%0d", i), mresp[i].rdata, sresp.rdata);
      end
      chk("model_outstanding", 32'(outstanding), 32'(m_q.size()));
      chk("model_err", 32'(err), 32'(m_err));
    end

    if (rst) begin
      m_q.delete();
      m_rr    = 0;
      m_lidx  = 0;
      m_lock  = 0;
      m_err   = 0;
      m_valid = 1;
    end else if (m_valid) begin
      if (sresp.rvalid && m_q.size() == 0) m_err = 1;
      if (pop) void'(m_q.pop_front());
      if (hs) begin
        m_q.push_back(sel);
        m_rr   = (sel + 1) % NM;
        m_lock = 0;
      end else if (exp_req) begin
        m_lock = 1;
        m_lidx = sel;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    for (int i = 0; i < NM; i++) mreq[i] = '0;
    sresp = '0;
  endtask

  task automatic setm(input int i, input logic r, input logic [31:0] a);
    mreq[i].req   = r;
    mreq[i].we    = a[8];
    mreq[i].be    = 4'hF;
    mreq[i].addr  = a;
    mreq[i].wdata = a ^ 32'h55AA_0F0F;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Literal per-cycle expectation: which master is granted / sees rvalid (-1 = none).
  task automatic exp_cyc(input string tag, input int g, input int rv, input logic [31:0] rd);
    for (int i = 0; i < NM; i++) begin
      chk($sformatf("%s_gnt_m%0d", tag, i), 32'(mresp[i].gnt), 32'(i == g));
      chk($sformatf("%s_rvalid_m%0d", tag, i), 32'(mresp[i].rvalid), 32'(i == rv));
    end
    if (rv >= 0) chk($sformatf("%s_rdata", tag), mresp[rv].rdata, rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    idle();
    rst = 1'b1;
    repeat (3) step();
    #3;
    chk("rst_outstanding", 32'(outstanding), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_slave_req", 32'(sreq.req), 32'd0);
    exp_cyc("rst", -1, -1, 32'd0);
    rst = 1'b0;

    // T1 single master read
    step(); setm(0, 1'b1, 32'h1000); sresp.gnt = 1'b1; #3;
    exp_cyc("t1_c0", 0, -1, 32'd0);
    chk("t1_addr", sreq.addr, 32'h1000);
    chk("t1_out_c0", 32'(outstanding), 32'd0);
    step(); setm(0, 1'b0, 32'h0); sresp.gnt = 1'b0; #3;
    chk("t1_out_c1", 32'(outstanding), 32'd1);
    exp_cyc("t1_c1", -1, -1, 32'd0);
    step(); sresp.rvalid = 1'b1; sresp.rdata = 32'hCAFE0001; #3;
    exp_cyc("t1_c2", -1, 0, 32'hCAFE0001);
    step(); sresp.rvalid = 1'b0; #3;
    chk("t1_out_c3", 32'(outstanding), 32'd0);
    exp_cyc("t1_c3", -1, -1, 32'd0);

    // T2 contention
    do_reset();
    step(); setm(0, 1'b1, 32'h3000); setm(1, 1'b1, 32'h3100); sresp.gnt = 1'b1; #3;
    exp_cyc("t2_c0", 0, -1, 32'd0);
    step(); sresp.rvalid = 1'b1; sresp.rdata = 32'hA; #3;
    exp_cyc("t2_c1", 1, 0, 32'hA);
    step(); sresp.rdata = 32'hB; #3;
    exp_cyc("t2_c2", 0, 1, 32'hB);
    step(); sresp.rdata = 32'hC; #3;
    exp_cyc("t2_c3", 1, 0, 32'hC);
    step(); setm(0, 1'b0, 32'h0); setm(1, 1'b0, 32'h0); sresp.gnt = 1'b0; sresp.rdata = 32'hD; #3;
    exp_cyc("t2_c4", -1, 1, 32'hD);
    step(); idle(); #3;
    chk("t2_out_end", 32'(outstanding), 32'd0);

    // T3 address-phase lock
    do_reset();
    step(); setm(1, 1'b1, 32'h2000); sresp.gnt = 1'b0; #3;
    chk("t3_addr_c0", sreq.addr, 32'h2000);
    exp_cyc("t3_c0", -1, -1, 32'd0);
    step(); setm(0, 1'b1, 32'h1100); #3;
    chk("t3_addr_c1", sreq.addr, 32'h2000);
    exp_cyc("t3_c1", -1, -1, 32'd0);
    step(); #3;
    chk("t3_addr_c2", sreq.addr, 32'h2000);
    step(); sresp.gnt = 1'b1; #3;
    chk("t3_addr_c3", sreq.addr, 32'h2000);
    exp_cyc("t3_c3", 1, -1, 32'd0);
    step(); setm(1, 1'b0, 32'h0); #3;
    chk("t3_addr_c4", sreq.addr, 32'h1100);
    exp_cyc("t3_c4", 0, -1, 32'd0);
    step(); setm(0, 1'b0, 32'h0); sresp.gnt = 1'b0; sresp.rvalid = 1'b1; sresp.rdata = 32'h31; #3;
    exp_cyc("t3_c5", -1, 1, 32'h31);
    step(); sresp.rdata = 32'h32; #3;
    exp_cyc("t3_c6", -1, 0, 32'h32);
    step(); idle(); #3;
    chk("t3_out_end", 32'(outstanding), 32'd0);

    // T4 FIFO full
    do_reset();
    step(); setm(0, 1'b1, 32'h4000); setm(1, 1'b1, 32'h4100); sresp.gnt = 1'b1; #3;
    exp_cyc("t4_c0", 0, -1, 32'd0);
    step(); #3;
    exp_cyc("t4_c1", 1, -1, 32'd0);
    step(); #3;
    chk("t4_out_full", 32'(outstanding), 32'd2);
    chk("t4_req_full", 32'(sreq.req), 32'd0);
    exp_cyc("t4_c2", -1, -1, 32'd0);
    step(); #3;
    chk("t4_req_full_c3", 32'(sreq.req), 32'd0);
    step(); sresp.rvalid = 1'b1; sresp.rdata = 32'h44; #3;
    chk("t4_req_popcyc", 32'(sreq.req), 32'd0);
    exp_cyc("t4_c4", -1, 0, 32'h44);
    step(); sresp.rvalid = 1'b0; #3;
    chk("t4_out_c5", 32'(outstanding), 32'd1);
    exp_cyc("t4_c5", 0, -1, 32'd0);
    step(); setm(0, 1'b0, 32'h0); setm(1, 1'b0, 32'h0); sresp.rvalid = 1'b1; sresp.rdata = 32'h45; #3;
    chk("t4_out_c6", 32'(outstanding), 32'd2);
    exp_cyc("t4_c6", -1, 1, 32'h45);
    step(); sresp.rdata = 32'h46; #3;
    exp_cyc("t4_c7", -1, 0, 32'h46);
    step(); idle(); #3;
    chk("t4_out_end", 32'(outstanding), 32'd0);

    // T5 spurious rvalid
    step(); sresp.rvalid = 1'b1; sresp.rdata = 32'hBAD; #3;
    exp_cyc("t5_c0", -1, -1, 32'd0);
    chk("t5_err_c0", 32'(err), 32'd0);
    step(); sresp.rvalid = 1'b0; #3;
    chk("t5_err_c1", 32'(err), 32'd1);
    step(); #3;
    chk("t5_err_hold", 32'(err), 32'd1);

    // T6 reset with two outstanding
    step(); setm(0, 1'b1, 32'h6000); setm(1, 1'b1, 32'h6100); sresp.gnt = 1'b1; #3;
    exp_cyc("t6_c0", 1, -1, 32'd0);
    step(); #3;
    exp_cyc("t6_c1", 0, -1, 32'd0);
    step(); idle(); #3;
    chk("t6_out_pre", 32'(outstanding), 32'd2);
    chk("t6_err_pre", 32'(err), 32'd1);
    rst = 1'b1;
    step(); rst = 1'b0;
    setm(0, 1'b1, 32'h6000); setm(1, 1'b1, 32'h6100); sresp.gnt = 1'b1; #3;
    chk("t6_out_post", 32'(outstanding), 32'd0);
    chk("t6_err_post", 32'(err), 32'd0);
    exp_cyc("t6_restart", 0, -1, 32'd0);
    step(); idle(); sresp.rvalid = 1'b1; sresp.rdata = 32'h61; #3;
    exp_cyc("t6_drain", -1, 0, 32'h61);
    step(); idle(); #3;
    chk("t6_out_end", 32'(outstanding), 32'd0);

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
